// File: rtl/fir_param_core.sv
// Streaming FIR engine: AXI-Lite programmed taps/length/shift, AXI-Stream samples,
// one multiply-accumulate per clock over a runtime-selected number of taps.
module fir_param_core #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_TAPS   = 16,
  parameter int pACC_WIDTH  = 72
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);
  localparam int AW = pADDR_WIDTH;
  localparam int DW = pDATA_WIDTH;
  localparam int KW = (pMAX_TAPS > 1) ? $clog2(pMAX_TAPS) : 1;
  localparam int NW = $clog2(pMAX_TAPS + 1);
  localparam logic [AW-1:0] A_CTRL   = AW'('h00);
  localparam logic [AW-1:0] A_LEN    = AW'('h10);
  localparam logic [AW-1:0] A_TAPN   = AW'('h14);
  localparam logic [AW-1:0] A_SHIFT  = AW'('h18);
  localparam logic [AW-1:0] A_TAP0   = AW'('h20);
  localparam logic [AW-1:0] A_LOCKHI = AW'('h7F);
  localparam logic [AW-1:0] A_TAPEND = AW'('h20 + 4 * pMAX_TAPS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;
  state_t r_state, w_nstate;

  logic [DW-1:0]         r_taps [pMAX_TAPS];
  logic [DW-1:0]         r_hist [pMAX_TAPS];
  logic [DW-1:0]         r_len, r_out_cnt, r_rdata;
  logic [NW-1:0]         r_tap_num;
  logic [4:0]            r_shift;
  logic [KW-1:0]         r_k;
  logic signed [pACC_WIDTH-1:0] r_acc;
  logic r_wack, r_arack, r_rvalid, r_ap_idle, r_ap_done, r_start_flag, r_tlast_err;

  logic                  w_wr, w_start, w_lock, w_wr_tap, w_rd_tap, w_k_last, w_final;
  logic [KW-1:0]         w_wr_idx, w_rd_idx;
  logic signed [2*DW-1:0] w_prod;
  logic [DW-1:0]         w_rd_data;

  assign w_wr     = r_wack & awvalid & wvalid;
  assign w_start  = w_wr && (awaddr == A_CTRL) && wdata[0] && r_ap_idle;
  // Config space is frozen while a run is in flight; the handshake still completes.
  assign w_lock   = !r_ap_idle && (awaddr >= A_LEN) && (awaddr <= A_LOCKHI);
  assign w_wr_tap = (awaddr >= A_TAP0) && (awaddr < A_TAPEND) && (awaddr[1:0] == 2'b00);
  assign w_rd_tap = (araddr >= A_TAP0) && (araddr < A_TAPEND) && (araddr[1:0] == 2'b00);
  assign w_wr_idx = KW'((awaddr - A_TAP0) >> 2);
  assign w_rd_idx = KW'((araddr - A_TAP0) >> 2);
  assign w_k_last = (NW'(r_k) == r_tap_num - NW'(1));
  assign w_final  = (r_out_cnt == r_len - DW'(1));
  assign w_prod   = $signed(r_taps[r_k]) * $signed(r_hist[r_k]);

  assign awready   = r_wack;
  assign wready    = r_wack;
  assign arready   = r_arack;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign ss_tready = (r_state == S_WAIT_IN);
  assign sm_tvalid = (r_state == S_OUT);
  assign sm_tdata  = sm_tvalid ? DW'(r_acc >>> r_shift) : '0;
  assign sm_tlast  = sm_tvalid & w_final;

  always_comb begin
    w_rd_data = '0;
    if (araddr == A_CTRL)       w_rd_data = DW'({r_tlast_err, r_ap_idle, r_ap_done, r_start_flag});
    else if (araddr == A_LEN)   w_rd_data = r_len;
    else if (araddr == A_TAPN)  w_rd_data = DW'(r_tap_num);
    else if (araddr == A_SHIFT) w_rd_data = DW'(r_shift);
    else if (w_rd_tap)          w_rd_data = r_ap_idle ? r_taps[w_rd_idx] : '1;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_state <= S_IDLE;
    else             r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_nstate = (r_len == '0) ? S_DONE : S_WAIT_IN;
      S_WAIT_IN: if (ss_tvalid) w_nstate = S_MAC;
      S_MAC:     if (w_k_last) w_nstate = S_OUT;
      S_OUT:     if (sm_tready) w_nstate = (r_out_cnt + DW'(1) == r_len) ? S_DONE : S_WAIT_IN;
      S_DONE:    w_nstate = S_IDLE;
      default:   w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < pMAX_TAPS; i++) begin
        r_taps[i] <= '0;
        r_hist[i] <= '0;
      end
      r_len        <= '0;
      r_out_cnt    <= '0;
      r_rdata      <= '0;
      r_tap_num    <= NW'(pMAX_TAPS);
      r_shift      <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      r_wack       <= 1'b0;
      r_arack      <= 1'b0;
      r_rvalid     <= 1'b0;
      r_ap_idle    <= 1'b1;
      r_ap_done    <= 1'b0;
      r_start_flag <= 1'b0;
      r_tlast_err  <= 1'b0;
    end else begin
      r_wack       <= awvalid & wvalid & ~r_wack;
      r_arack      <= arvalid & ~r_arack & ~r_rvalid;
      r_start_flag <= w_start;
      if (r_arack && arvalid) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end
      if (w_wr && !w_lock) begin
        if (awaddr == A_LEN)        r_len <= wdata;
        else if (awaddr == A_TAPN)  r_tap_num <= (wdata == '0 || wdata > DW'(pMAX_TAPS))
                                                 ? NW'(pMAX_TAPS) : NW'(wdata);
        else if (awaddr == A_SHIFT) r_shift <= wdata[4:0];
        else if (w_wr_tap)          r_taps[w_wr_idx] <= wdata;
      end
      if (w_start) begin
        for (int i = 0; i < pMAX_TAPS; i++) r_hist[i] <= '0;
        r_out_cnt   <= '0;
        r_ap_idle   <= 1'b0;
        r_ap_done   <= 1'b0;
        r_tlast_err <= 1'b0;
      end
      case (r_state)
        S_WAIT_IN: if (ss_tvalid) begin
          for (int i = pMAX_TAPS - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
          r_hist[0] <= ss_tdata;
          r_acc     <= '0;
          r_k       <= '0;
          if (ss_tlast != w_final) r_tlast_err <= 1'b1;
        end
        S_MAC: begin
          r_acc <= r_acc + {{(pACC_WIDTH-2*DW){w_prod[2*DW-1]}}, w_prod};
          r_k   <= r_k + KW'(1);
        end
        S_OUT: if (sm_tready) r_out_cnt <= r_out_cnt + DW'(1);
        S_DONE: begin
          r_ap_done <= 1'b1;
          r_ap_idle <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_param_core.sv
// Directed bench for fir_param_core: AXI-Lite programming, streamed samples
// checked against a convolution model through an expected-result queue.
module tb_fir_param_core;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast, sm_tready;
  logic        awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata, ss_tdata, sm_tdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_taps [16];
  logic [31:0] m_x [$];
  int          m_ntap, m_shift, m_len;
  logic [31:0] sb_d [$];
  logic        sb_l [$];
  int          acc_q [$];
  logic [31:0] rd;

  fir_param_core dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fir_model(input int n);
    logic signed [71:0] acc;
    logic signed [71:0] sh;
    acc = '0;
    for (int k = 0; k < m_ntap; k++)
      if (n - k >= 0) acc += 72'($signed(m_taps[k])) * 72'($signed(m_x[n-k]));
    sh = acc >>> m_shift;
    return sh[31:0];
  endfunction

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int  n;
    logic ok;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while (!awready && n < 50) begin step(); n++; end
    ok = awready && wready;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    ok = ok && !awready && !wready;
    chk("wr_handshake", {31'b0, ok}, 32'd1);
  endtask

  task automatic rd_reg(input logic [11:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1; n = 0; d = 'x;
    while (!arready && n < 50) begin step(); n++; end
    step();
    arvalid = 1'b0; n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    if (rvalid) d = rdata;
    step();
  endtask

  task automatic cfg(input int ntap, input int sh, input int len);
    wr(12'h14, ntap); wr(12'h18, sh); wr(12'h10, len);
    m_ntap = ntap; m_shift = sh; m_len = len;
  endtask

  task automatic set_tap(input int k, input int v);
    wr(12'(32'h20 + 4 * k), v);
    m_taps[k] = v;
  endtask

  task automatic start();
    m_x.delete(); sb_d.delete(); sb_l.delete(); acc_q.delete();
    wr(12'h00, 32'd1);
  endtask

  // Push the expected result at drive time; pop when the output shows up.
  task automatic xfer(input int x, input logic last, input int stall);
    int n;
    logic stable;
    logic [31:0] held;
    m_x.push_back(x);
    n = m_x.size() - 1;
    sb_d.push_back(fir_model(n));
    sb_l.push_back(n == m_len - 1);
    ss_tdata = x; ss_tlast = last; ss_tvalid = 1'b1; n = 0;
    while (!ss_tready && n < 200) begin step(); n++; end
    chk("ss_accept", {31'b0, ss_tready}, 32'd1);
    step();
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
    acc_q.push_back(cyc);
    n = 0;
    while (!sm_tvalid && n < 200) begin step(); n++; end
    chk("sm_valid", {31'b0, sm_tvalid}, 32'd1);
    if (stall > 0) begin
      sm_tready = 1'b0; held = sm_tdata; stable = 1'b1;
      repeat (stall) begin
        step();
        if (sm_tvalid !== 1'b1 || sm_tdata !== held || ss_tready !== 1'b0) stable = 1'b0;
      end
      chk("stall_stable", {31'b0, stable}, 32'd1);
      sm_tready = 1'b1;
    end
    chk("sm_tdata", sm_tdata, sb_d.pop_front());
    chk("sm_tlast", {31'b0, sm_tlast}, {31'b0, sb_l.pop_front()});
    step();
  endtask

  initial begin
    rst_n = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; rready = 1; ss_tvalid = 0;
    ss_tlast = 0; sm_tready = 1; awaddr = 0; araddr = 0; wdata = 0; ss_tdata = 0;
    for (int i = 0; i < 16; i++) m_taps[i] = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_outs", {25'b0, awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_sm_tdata", sm_tdata, 32'd0);
    rd_reg(12'h00, rd); chk("rst_ctrl", rd, 32'h4);
    rd_reg(12'h14, rd); chk("rst_tapnum", rd, 32'd16);
    rd_reg(12'h10, rd); chk("rst_len", rd, 32'd0);

    wr(12'h14, 0);  rd_reg(12'h14, rd); chk("tapnum_clamp0", rd, 32'd16);
    wr(12'h14, 17); rd_reg(12'h14, rd); chk("tapnum_clamp17", rd, 32'd16);
    wr(12'h14, 5);  rd_reg(12'h14, rd); chk("tapnum_5", rd, 32'd5);
    wr(12'h18, 32'h23); rd_reg(12'h18, rd); chk("shift_mask", rd, 32'd3);
    wr(12'h80, 32'h55); rd_reg(12'h80, rd); chk("unmapped", rd, 32'd0);

    // Impulse response of an 11-tap symmetric filter
    begin
      int t [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
      for (int k = 0; k < 11; k++) set_tap(k, t[k]);
    end
    cfg(11, 0, 12);
    start();
    for (int i = 0; i < 12; i++) xfer((i == 0) ? 1 : 0, i == 11, 0);
    rd_reg(12'h00, rd); chk("t1_ctrl_done", rd, 32'h6);

    set_tap(0, 1); set_tap(1, 2); set_tap(2, 3);
    cfg(3, 1, 3);
    start();
    for (int i = 0; i < 3; i++) xfer(4, i == 2, 0);
    chk("t2_throughput", 32'(acc_q[1] - acc_q[0]), 32'd5);

    cfg(3, 1, 2);
    start();
    xfer(-4, 1'b0, 0);
    xfer(7, 1'b1, 0);

    cfg(3, 0, 2);
    start();
    wr(12'h20, 99);
    rd_reg(12'h20, rd); chk("tap_rd_busy", rd, 32'hFFFF_FFFF);
    xfer(5, 1'b0, 0);
    xfer(6, 1'b1, 0);
    rd_reg(12'h20, rd); chk("tap_rd_after", rd, 32'd1);

    cfg(3, 0, 3);
    start();
    xfer(5, 1'b0, 0);
    xfer(6, 1'b0, 20);
    xfer(7, 1'b1, 0);

    cfg(3, 0, 0);
    start();
    chk("len0_no_stream", {30'b0, ss_tready, sm_tvalid}, 32'd0);
    rd_reg(12'h00, rd); chk("len0_ctrl", rd, 32'h6);

    cfg(3, 0, 4);
    start();
    xfer(1, 1'b0, 0);
    xfer(2, 1'b1, 0);
    xfer(3, 1'b0, 0);
    xfer(4, 1'b0, 0);
    rd_reg(12'h00, rd); chk("tlast_err_set", rd, 32'hE);
    start();
    rd_reg(12'h00, rd); chk("tlast_err_clr", rd, 32'h0);

    // Reset while the MAC loop is running
    ss_tdata = 9; ss_tvalid = 1'b1;
    chk("mid_ready", {31'b0, ss_tready}, 32'd1);
    step();
    ss_tvalid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {25'b0, awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 32'd0);
    chk("mid_rst_tdata", sm_tdata, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    rd_reg(12'h00, rd); chk("mid_rst_ctrl", rd, 32'h4);
    rd_reg(12'h20, rd); chk("mid_rst_tap0", rd, 32'd0);
    for (int i = 0; i < 16; i++) m_taps[i] = '0;
    set_tap(0, 1); set_tap(1, 2); set_tap(2, 3);
    cfg(3, 0, 3);
    start();
    xfer(2, 1'b0, 0);
    xfer(3, 1'b0, 0);
    xfer(4, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
